// File: rtl/maxpool2x2_stream_if.sv
`default_nettype none
// ============================================================================
// maxpool2x2_stream_if : pixel-in / pooled-pixel-out stream handshake bundle
// Rev 1.0
// ============================================================================
interface maxpool2x2_stream_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              frame_done;

   // slave is the pooling block's view, master is the producer/consumer side
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, frame_done
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// maxpool2x2_stream : streaming 2x2 / stride-2 unsigned max-pool, raster order
// Rev 1.0
// ============================================================================
module maxpool2x2_stream #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  wire logic           clk,
   input  wire logic           rst,
   maxpool2x2_stream_if.slave  bus
);
   localparam int C_HALF_W = IMG_W / 2;
   localparam int C_COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int C_ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int C_IDX_W  = (C_HALF_W > 1) ? $clog2(C_HALF_W) : 1;

   generate
      if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
         $error("maxpool2x2_stream: IMG_W must be even and >= 2");
      end
      if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
         $error("maxpool2x2_stream: IMG_H must be even and >= 2");
      end
   endgenerate

   logic [C_COL_W-1:0] col_q, col_d;
   logic [C_ROW_W-1:0] row_q, row_d;
   logic [DATA_W-1:0]  pair_q, pair_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               frame_done_q, frame_done_d;

   // Horizontal-pair maxima of the most recent even row
   logic [DATA_W-1:0]  line_buf [C_HALF_W];

   logic               w_in_ready;
   logic               w_accept;
   logic               w_col_last;
   logic               w_row_last;
   logic [C_IDX_W-1:0] w_idx;
   logic [DATA_W-1:0]  w_hmax;
   logic [DATA_W-1:0]  w_lb_rd;
   logic [DATA_W-1:0]  w_vmax;
   logic               w_lb_we;

   assign w_in_ready = rst | ~out_valid_q | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_col_last = (col_q == C_COL_W'(IMG_W - 1));
   assign w_row_last = (row_q == C_ROW_W'(IMG_H - 1));
   assign w_idx      = C_IDX_W'(col_q >> 1);
   assign w_hmax     = (pair_q > bus.in_data) ? pair_q : bus.in_data;
   assign w_lb_rd    = line_buf[w_idx];
   assign w_vmax     = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q & ~bus.out_ready;
      frame_done_d = 1'b0;
      w_lb_we      = 1'b0;

      if (w_accept && !rst) begin
         if (w_col_last) begin
            col_d = '0;
            row_d = w_row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         if (!col_q[0]) begin
            pair_d = bus.in_data;
         end else if (!row_q[0]) begin
            w_lb_we = 1'b1;
         end else begin
            // A new result may replace one being consumed this same cycle
            out_data_d   = w_vmax;
            out_valid_d  = 1'b1;
            frame_done_d = w_col_last & w_row_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         pair_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Every entry is written on an even row before the odd row reads it
   always_ff @(posedge clk) begin
      if (w_lb_we) begin
         line_buf[w_idx] <= w_hmax;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// tb_maxpool2x2_stream : directed self-checking bench, 4x4 frames
// Rev 1.0
// ============================================================================
module tb_maxpool2x2_stream;
   typedef logic [31:0] frame_t [16];
   typedef logic [31:0] res_t [4];

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   int   fd_cnt;
   logic [31:0] fd_data;
   logic [31:0] got_q [$];

   maxpool2x2_stream_if #(.DATA_W(32)) bus ();

   maxpool2x2_stream #(
      .DATA_W (32),
      .IMG_W  (4),
      .IMG_H  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every completed output transfer and frame_done pulse
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
         got_q.push_back(bus.out_data);
      if (rst === 1'b0 && bus.frame_done === 1'b1) begin
         fd_cnt  = fd_cnt + 1;
         fd_data = bus.out_data;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_obs();
      got_q.delete();
      fd_cnt  = 0;
      fd_data = '0;
   endtask

   task automatic send_px(input logic [31:0] d);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = (bus.in_ready === 1'b1);
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         n_assert++;
         n_fail++;
         $display("FAIL accept_timeout: pixel %0h never accepted within %0d cycles", d, n);
      end
   endtask

   task automatic send_frame(input frame_t f);
      for (int i = 0; i < 16; i++) send_px(f[i]);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'd99;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_assert++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
         end
         n_assert++;
         if (bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
         end
         n_assert++;
         if (bus.out_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data);
         end
         n_assert++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      wait_cycles(2);
      n_assert++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_basic();
      frame_t f;
      res_t   e;
      for (int i = 0; i < 16; i++) f[i] = 32'(i + 1);
      e = '{32'd6, 32'd8, 32'd14, 32'd16};
      clear_obs();
      send_frame(f);
      idle();
      wait_cycles(4);
      n_assert++;
      if (got_q.size() !== 4) begin
         n_fail++; $display("FAIL basic_count: got %0d outputs want 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (i >= got_q.size() || got_q[i] !== e[i]) begin
            n_fail++;
            $display("FAIL basic_out[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 32'hx, e[i]);
         end
      end
      n_assert++;
      if (fd_cnt !== 1 || fd_data !== 32'd16) begin
         n_fail++; $display("FAIL basic_frame_done: got %0d pulses data %0h want 1 pulse data 10", fd_cnt, fd_data);
      end
   endtask

   task automatic test_unsigned_tie();
      frame_t f;
      res_t   e;
      f = '{32'hFFFFFFFF, 32'd1, 32'd5, 32'd5,
            32'd0, 32'd7, 32'd5, 32'd5,
            32'h80000000, 32'h7FFFFFFF, 32'd2, 32'd9,
            32'd1, 32'd0, 32'd9, 32'd2};
      e = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd9};
      clear_obs();
      send_frame(f);
      idle();
      wait_cycles(4);
      n_assert++;
      if (got_q.size() !== 4) begin
         n_fail++; $display("FAIL unsigned_count: got %0d outputs want 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (i >= got_q.size() || got_q[i] !== e[i]) begin
            n_fail++;
            $display("FAIL unsigned_out[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 32'hx, e[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      frame_t f;
      res_t   e;
      for (int i = 0; i < 16; i++) f[i] = 32'(i + 1);
      e = '{32'd6, 32'd8, 32'd14, 32'd16};
      clear_obs();
      bus.out_ready = 1'b0;
      fork
         send_frame(f);
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (bus.out_valid !== 1'b1 && n < 200);
            n_assert++;
            if (bus.out_valid !== 1'b1) begin
               n_fail++; $display("FAIL bp_first_valid: no out_valid within %0d cycles", n);
            end
            for (int k = 0; k < 5; k++) begin
               n_assert++;
               if (bus.out_data !== 32'd6 || bus.out_valid !== 1'b1) begin
                  n_fail++; $display("FAIL bp_hold[%0d]: got data %0h valid %b want 6 valid 1", k, bus.out_data, bus.out_valid);
               end
               n_assert++;
               if (bus.in_ready !== 1'b0) begin
                  n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready);
               end
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      idle();
      wait_cycles(4);
      n_assert++;
      if (got_q.size() !== 4) begin
         n_fail++; $display("FAIL bp_count: got %0d outputs want 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (i >= got_q.size() || got_q[i] !== e[i]) begin
            n_fail++;
            $display("FAIL bp_out[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 32'hx, e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      frame_t f1;
      frame_t f2;
      logic [31:0] e [8];
      for (int i = 0; i < 16; i++) begin
         f1[i] = 32'(i + 1);
         f2[i] = 32'(16 - i);
      end
      e = '{32'd6, 32'd8, 32'd14, 32'd16, 32'd16, 32'd14, 32'd8, 32'd6};
      clear_obs();
      bus.out_ready = 1'b1;
      send_frame(f1);
      send_frame(f2);
      idle();
      wait_cycles(4);
      n_assert++;
      if (got_q.size() !== 8) begin
         n_fail++; $display("FAIL b2b_count: got %0d outputs want 8", got_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         n_assert++;
         if (i >= got_q.size() || got_q[i] !== e[i]) begin
            n_fail++;
            $display("FAIL b2b_out[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 32'hx, e[i]);
         end
      end
      n_assert++;
      if (fd_cnt !== 2) begin
         n_fail++; $display("FAIL b2b_frame_done: got %0d pulses want 2", fd_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      frame_t f;
      res_t   e;
      for (int i = 0; i < 16; i++) f[i] = 32'(i + 1);
      e = '{32'd6, 32'd8, 32'd14, 32'd16};
      clear_obs();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) send_px(32'(101 + i));
      idle();
      wait_cycles(3);
      n_assert++;
      if (got_q.size() !== 2 || got_q[0] !== 32'd106 || got_q[1] !== 32'd108) begin
         n_fail++; $display("FAIL abort_partial: got %0d outputs want 2 (106,108)", got_q.size());
      end
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd77;
      wait_cycles(2);
      @(negedge clk);
      n_assert++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_reset_state: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      clear_obs();
      send_frame(f);
      idle();
      wait_cycles(4);
      n_assert++;
      if (got_q.size() !== 4) begin
         n_fail++; $display("FAIL restart_count: got %0d outputs want 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (i >= got_q.size() || got_q[i] !== e[i]) begin
            n_fail++;
            $display("FAIL restart_out[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 32'hx, e[i]);
         end
      end
      n_assert++;
      if (fd_cnt !== 1 || fd_data !== 32'd16) begin
         n_fail++; $display("FAIL restart_frame_done: got %0d pulses data %0h want 1 pulse data 10", fd_cnt, fd_data);
      end
   endtask

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      fd_cnt        = 0;
      fd_data       = '0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      test_reset();
      test_basic();
      test_unsigned_tie();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
